// File: rtl/ex_branch_rs_pkg.sv
// ---------------------------------------------------------------------------
// ex_branch_rs_pkg
//   Shared definitions for the branch reservation station: branch opcode
//   encoding, default datapath widths, the "operand present" tag value and
//   the word/address/tag types used by the allocator interface.
// ---------------------------------------------------------------------------
package ex_branch_rs_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 4;

    // A source tag equal to UNLOCKED means the operand data is already valid.
    localparam int UNLOCKED = 0;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLT  = 3'd2,
        OP_BGE  = 3'd3,
        OP_BLTU = 3'd4,
        OP_BGEU = 3'd5,
        OP_JALR = 3'd6
    } sinst_t;

    typedef logic [TAG_W_DEF-1:0] regtag_t;
    typedef logic [XLEN_DEF-1:0]  word_t;
    typedef logic [XLEN_DEF-1:0]  addr_t;

endpackage

// File: rtl/ex_branch_rs_br_resolve.sv
// ---------------------------------------------------------------------------
// br_resolve
//   Combinational branch resolver.
//   Ports:
//     op      in   branch opcode (sinst_t)
//     datax   in   first source operand
//     datay   in   second source operand
//     pc      in   branch PC
//     offset  in   sign-extended immediate
//     taken   out  redirect required
//     dest    out  next PC: pc+offset if taken, pc+4 otherwise;
//                  JALR: (datax+offset) with bit 0 cleared
// ---------------------------------------------------------------------------
module br_resolve
    import ex_branch_rs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  sinst_t            op,
    input  logic [XLEN-1:0]   datax,
    input  logic [XLEN-1:0]   datay,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   offset,
    output logic              taken,
    output logic [XLEN-1:0]   dest
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic cond;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        cond = 1'b0;
        case (op)
            OP_BEQ:  cond = (datax == datay);
            OP_BNE:  cond = (datax != datay);
            OP_BLT:  cond = ($signed(datax) <  $signed(datay));
            OP_BGE:  cond = ($signed(datax) >= $signed(datay));
            OP_BLTU: cond = (datax <  datay);
            OP_BGEU: cond = (datax >= datay);
            OP_JALR: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        taken = cond;
        if (op == OP_JALR) begin
            dest = (datax + offset) & JALR_MASK;
        end else if (cond) begin
            dest = pc + offset;
        end else begin
            dest = pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/ex_branch_rs.sv
// ---------------------------------------------------------------------------
// ex_branch_rs
//   In-order branch reservation station with integrated resolver. Holds up
//   to ENTRIES branches in a circular buffer, snoops the CDB for missing
//   operands and resolves the oldest entry once both operands are present,
//   producing a registered one-cycle redirect pulse toward fetch.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     rdy                      global stall (0 freezes everything)
//     alloc_valid/alloc_ready  push handshake from the allocator
//     alloc_pc/offset/op       branch PC, immediate, opcode
//     alloc_tagx/y, datax/y    source tags (UNLOCKED = data valid) and data
//     cdb_valid/tag/data       result broadcast
//     flush                    squash all entries
//     res_valid/taken/dest     registered resolve result
//     busy, count              occupancy
// ---------------------------------------------------------------------------
module ex_branch_rs
    import ex_branch_rs_pkg::*;
#(
    parameter  int ENTRIES = 4,
    parameter  int XLEN    = XLEN_DEF,
    parameter  int TAG_W   = TAG_W_DEF,
    localparam int PTR_W   = $clog2(ENTRIES),
    localparam int CNT_W   = $clog2(ENTRIES) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [XLEN-1:0]   alloc_pc,
    input  logic [XLEN-1:0]   alloc_offset,
    input  sinst_t            alloc_op,
    input  logic [TAG_W-1:0]  alloc_tagx,
    input  logic [TAG_W-1:0]  alloc_tagy,
    input  logic [XLEN-1:0]   alloc_datax,
    input  logic [XLEN-1:0]   alloc_datay,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [XLEN-1:0]   cdb_data,
    input  logic              flush,
    output logic              res_valid,
    output logic              res_taken,
    output logic [XLEN-1:0]   res_dest,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);

    localparam logic [TAG_W-1:0] UNLOCKED_TAG = TAG_W'(UNLOCKED);

    typedef struct packed {
        sinst_t            op;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   offset;
        logic [TAG_W-1:0]  tagx;
        logic [TAG_W-1:0]  tagy;
        logic [XLEN-1:0]   datax;
        logic [XLEN-1:0]   datay;
    } entry_t;

    entry_t             ent_q [ENTRIES];
    entry_t             ent_d [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               res_valid_q, res_valid_d;
    logic               res_taken_q, res_taken_d;
    logic [XLEN-1:0]    res_dest_q, res_dest_d;

    entry_t             head_ent;
    logic               head_ready;
    logic               do_push;
    logic               rs_taken;
    logic [XLEN-1:0]    rs_dest;

    // A locked tag matching the current broadcast picks up the CDB value.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        return cdb_valid && (tag != UNLOCKED_TAG) && (tag == cdb_tag);
    endfunction

    // Issue decision uses state at cycle start only: no CDB bypass into issue.
    assign head_ent   = ent_q[head_q];
    assign head_ready = valid_q[head_q] && (head_ent.tagx == UNLOCKED_TAG)
                        && (head_ent.tagy == UNLOCKED_TAG);
    assign alloc_ready = (count_q != CNT_W'(ENTRIES));
    assign do_push     = alloc_valid && alloc_ready;

    br_resolve #(.XLEN(XLEN)) u_resolve (
        .op     (head_ent.op),
        .datax  (head_ent.datax),
        .datay  (head_ent.datay),
        .pc     (head_ent.pc),
        .offset (head_ent.offset),
        .taken  (rs_taken),
        .dest   (rs_dest)
    );

    always_comb begin
        ent_d       = ent_q;
        valid_d     = valid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_taken_d = res_taken_q;
        res_dest_d  = res_dest_q;

        if (rdy) begin
            if (flush) begin
                // Flush wins over push, issue and capture; res_dest holds.
                valid_d     = '0;
                head_d      = '0;
                tail_d      = '0;
                count_d     = '0;
                res_valid_d = 1'b0;
                res_taken_d = 1'b0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (valid_q[i] && cdb_hit(ent_q[i].tagx)) begin
                        ent_d[i].tagx  = UNLOCKED_TAG;
                        ent_d[i].datax = cdb_data;
                    end
                    if (valid_q[i] && cdb_hit(ent_q[i].tagy)) begin
                        ent_d[i].tagy  = UNLOCKED_TAG;
                        ent_d[i].datay = cdb_data;
                    end
                end

                res_valid_d = head_ready;
                res_taken_d = head_ready && rs_taken;
                if (head_ready) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_W'(1);
                    res_dest_d      = rs_dest;
                end

                // The tail slot is never the issuing head here: push needs !full.
                if (do_push) begin
                    ent_d[tail_q].op     = alloc_op;
                    ent_d[tail_q].pc     = alloc_pc;
                    ent_d[tail_q].offset = alloc_offset;
                    ent_d[tail_q].tagx   = cdb_hit(alloc_tagx) ? UNLOCKED_TAG : alloc_tagx;
                    ent_d[tail_q].datax  = cdb_hit(alloc_tagx) ? cdb_data : alloc_datax;
                    ent_d[tail_q].tagy   = cdb_hit(alloc_tagy) ? UNLOCKED_TAG : alloc_tagy;
                    ent_d[tail_q].datay  = cdb_hit(alloc_tagy) ? cdb_data : alloc_datay;
                    valid_d[tail_q]      = 1'b1;
                    tail_d               = tail_q + PTR_W'(1);
                end

                if (do_push && !head_ready) begin
                    count_d = count_q + CNT_W'(1);
                end else if (!do_push && head_ready) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops update together from values computed before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_dest_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            res_dest_q  <= res_dest_d;
        end
    end

    // NOTE: the payload array is not reset; the valid bits alone decide
    // whether an entry's contents are meaningful.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign res_valid = res_valid_q;
    assign res_taken = res_taken_q;
    assign res_dest  = res_dest_q;
    assign busy      = (count_q != '0);
    assign count     = count_q;

endmodule

// File: tb/tb_ex_branch_rs.sv
// ---------------------------------------------------------------------------
// tb_ex_branch_rs
//   Self-checking bench for ex_branch_rs. A queue-based reference model
//   tracks the buffered branches in program order and is advanced once per
//   clock alongside the DUT; directed scenarios check literal values and the
//   randomized run compares every output against the model.
// ---------------------------------------------------------------------------
module tb_ex_branch_rs;
    import ex_branch_rs_pkg::*;

    localparam int ENTRIES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_pc;
    logic [31:0] alloc_offset;
    sinst_t      alloc_op;
    logic [3:0]  alloc_tagx;
    logic [3:0]  alloc_tagy;
    logic [31:0] alloc_datax;
    logic [31:0] alloc_datay;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_dest;
    logic        busy;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    ex_branch_rs #(.ENTRIES(ENTRIES), .XLEN(32), .TAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_pc     (alloc_pc),
        .alloc_offset (alloc_offset),
        .alloc_op     (alloc_op),
        .alloc_tagx   (alloc_tagx),
        .alloc_tagy   (alloc_tagy),
        .alloc_datax  (alloc_datax),
        .alloc_datay  (alloc_datay),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .flush        (flush),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_dest     (res_dest),
        .busy         (busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        sinst_t      op;
        logic [31:0] pc;
        logic [31:0] off;
        logic [31:0] x;
        logic [31:0] y;
        bit          rx;
        bit          ry;
        logic [3:0]  tx;
        logic [3:0]  ty;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        exp_valid;
    logic        exp_taken;
    logic [31:0] exp_dest;

    function automatic void m_resolve(input m_ent_t e, output logic tk, output logic [31:0] dst);
        case (e.op)
            OP_BEQ:  tk = (e.x == e.y);
            OP_BNE:  tk = (e.x != e.y);
            OP_BLT:  tk = ($signed(e.x) <  $signed(e.y));
            OP_BGE:  tk = ($signed(e.x) >= $signed(e.y));
            OP_BLTU: tk = (e.x <  e.y);
            OP_BGEU: tk = (e.x >= e.y);
            default: tk = 1'b1;
        endcase
        if (e.op == OP_JALR) dst = (e.x + e.off) & 32'hFFFF_FFFE;
        else if (tk)         dst = e.pc + e.off;
        else                 dst = e.pc + 32'd4;
    endfunction

    task automatic model_step();
        int     n;
        bit     iss;
        m_ent_t e;
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_taken = 1'b0;
            exp_dest  = '0;
        end else if (rdy && flush) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_taken = 1'b0;
        end else if (rdy) begin
            n   = mq.size();
            iss = (n > 0) && mq[0].rx && mq[0].ry;
            if (iss) begin
                m_resolve(mq[0], exp_taken, exp_dest);
                exp_valid = 1'b1;
                void'(mq.pop_front());
            end else begin
                exp_valid = 1'b0;
                exp_taken = 1'b0;
            end
            for (int i = 0; i < mq.size(); i++) begin
                if (cdb_valid && !mq[i].rx && mq[i].tx == cdb_tag) begin
                    mq[i].x = cdb_data; mq[i].rx = 1'b1;
                end
                if (cdb_valid && !mq[i].ry && mq[i].ty == cdb_tag) begin
                    mq[i].y = cdb_data; mq[i].ry = 1'b1;
                end
            end
            if (alloc_valid && n < ENTRIES) begin
                e.op = alloc_op; e.pc = alloc_pc; e.off = alloc_offset;
                e.tx = alloc_tagx; e.ty = alloc_tagy;
                e.rx = 1'b1; e.ry = 1'b1;
                e.x  = alloc_datax; e.y = alloc_datay;
                if (alloc_tagx != 0) begin
                    e.rx = cdb_valid && (cdb_tag == alloc_tagx);
                    if (e.rx) e.x = cdb_data;
                end
                if (alloc_tagy != 0) begin
                    e.ry = cdb_valid && (cdb_tag == alloc_tagy);
                    if (e.ry) e.y = cdb_data;
                end
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input sinst_t op, input logic [31:0] pc, input logic [31:0] off,
                        input logic [3:0] tx, input logic [3:0] ty,
                        input logic [31:0] dx, input logic [31:0] dy);
        alloc_valid = 1'b1; alloc_op = op; alloc_pc = pc; alloc_offset = off;
        alloc_tagx = tx; alloc_tagy = ty; alloc_datax = dx; alloc_datay = dy;
        cycle();
        alloc_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        cycle();
        cdb_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || res_taken !== 1'b0 || res_dest !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_res: got v=%b t=%b d=%h want 0 0 00000000", res_valid, res_taken, res_dest);
        end
        n_checks++;
        if (count !== 3'd0 || busy !== 1'b0 || alloc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_occ: got count=%0d busy=%b ready=%b want 0 0 1", count, busy, alloc_ready);
        end
    endtask

    task automatic test_basic();
        push(OP_BEQ, 32'h100, 32'h20, 4'd0, 4'd0, 32'd5, 32'd5);
        n_checks++;
        if (res_valid !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL beq_latency: got v=%b count=%0d want 0 1", res_valid, count);
        end
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== 32'h120) begin
            n_fail++;
            $display("FAIL beq_taken: got v=%b t=%b d=%h want 1 1 00000120", res_valid, res_taken, res_dest);
        end
        push(OP_BLT, 32'h200, 32'h40, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'd1);
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== 32'h240) begin
            n_fail++;
            $display("FAIL blt_signed: got v=%b t=%b d=%h want 1 1 00000240", res_valid, res_taken, res_dest);
        end
        push(OP_BLTU, 32'h200, 32'h40, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'd1);
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_dest !== 32'h204) begin
            n_fail++;
            $display("FAIL bltu_unsigned: got v=%b t=%b d=%h want 1 0 00000204", res_valid, res_taken, res_dest);
        end
        push(OP_JALR, 32'h300, 32'h0, 4'd0, 4'd0, 32'h203, 32'h0);
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== 32'h202) begin
            n_fail++;
            $display("FAIL jalr_dest: got v=%b t=%b d=%h want 1 1 00000202", res_valid, res_taken, res_dest);
        end
        cycle();
        n_checks++;
        if (res_valid !== 1'b0 || res_taken !== 1'b0 || res_dest !== 32'h202) begin
            n_fail++;
            $display("FAIL pulse_hold: got v=%b t=%b d=%h want 0 0 00000202", res_valid, res_taken, res_dest);
        end
    endtask

    task automatic test_cdb_wakeup();
        push(OP_BEQ, 32'h400, 32'h10, 4'd3, 4'd0, 32'h0, 32'd7);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL locked_wait[%0d]: got v=%b want 0", i, res_valid);
            end
            if (i < 2) cycle();
        end
        cdb(4'd3, 32'd7);
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got v=%b want 0", res_valid);
        end
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== 32'h410) begin
            n_fail++;
            $display("FAIL wakeup_res: got v=%b t=%b d=%h want 1 1 00000410", res_valid, res_taken, res_dest);
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_d [5] = '{32'h1100, 32'h1110, 32'h1120, 32'h1130, 32'h3010};
        logic [2:0]  exp_c [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < ENTRIES; i++)
            push(OP_BEQ, 32'h1000 + 32'(16 * i), 32'h100, 4'd5, 4'd0, 32'h0, 32'd9);
        n_checks++;
        if (count !== 3'd4 || alloc_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full: got count=%0d ready=%b busy=%b want 4 0 1", count, alloc_ready, busy);
        end
        push(OP_BEQ, 32'h2000, 32'h4, 4'd0, 4'd0, 32'h0, 32'h0);
        n_checks++;
        if (count !== 3'd4) begin
            n_fail++;
            $display("FAIL push_when_full: got count=%0d want 4", count);
        end
        cdb(4'd5, 32'd9);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) push(OP_JALR, 32'h500, 32'h10, 4'd0, 4'd0, 32'h3001, 32'h0);
            else        cycle();
            n_checks++;
            if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== exp_d[i] || count !== exp_c[i]) begin
                n_fail++;
                $display("FAIL drain[%0d]: got v=%b t=%b d=%h count=%0d want 1 1 %h %0d",
                         i, res_valid, res_taken, res_dest, count, exp_d[i], exp_c[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (alloc_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_issue: got %b want 1", alloc_ready);
                end
            end
        end
    endtask

    task automatic test_in_order();
        push(OP_BEQ, 32'h600, 32'h8, 4'd6, 4'd0, 32'h0, 32'd4);
        push(OP_BNE, 32'h700, 32'h8, 4'd0, 4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (res_valid !== 1'b0 || count !== 3'd2) begin
                n_fail++;
                $display("FAIL head_blocks[%0d]: got v=%b count=%0d want 0 2", i, res_valid, count);
            end
        end
        cdb(4'd6, 32'd4);
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_dest !== 32'h608) begin
            n_fail++;
            $display("FAIL older_first: got v=%b d=%h want 1 00000608", res_valid, res_dest);
        end
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== 32'h708 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL younger_next: got v=%b t=%b d=%h count=%0d want 1 1 00000708 0",
                     res_valid, res_taken, res_dest, count);
        end
    endtask

    task automatic test_flush_stall();
        push(OP_BEQ, 32'h800, 32'h4, 4'd8, 4'd0, 32'h0, 32'h0);
        push(OP_BEQ, 32'h900, 32'h4, 4'd7, 4'd0, 32'h0, 32'h0);
        push(OP_BEQ, 32'h904, 32'h4, 4'd7, 4'd0, 32'h0, 32'h0);
        cdb(4'd8, 32'h0);
        flush = 1'b1;
        push(OP_BEQ, 32'hC00, 32'h4, 4'd0, 4'd0, 32'h0, 32'h0);
        flush = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0 || alloc_ready !== 1'b1 || res_dest !== 32'h708) begin
            n_fail++;
            $display("FAIL flush: got v=%b count=%0d busy=%b ready=%b d=%h want 0 0 0 1 00000708",
                     res_valid, count, busy, alloc_ready, res_dest);
        end
        cycle();
        n_checks++;
        if (res_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_drops_push: got v=%b count=%0d want 0 0", res_valid, count);
        end
        push(OP_BEQ, 32'hA00, 32'h40, 4'd0, 4'd0, 32'd1, 32'd1);
        rdy = 1'b0;
        alloc_valid = 1'b1; alloc_tagx = 4'd0; alloc_tagy = 4'd0;
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h55;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (res_valid !== 1'b0 || count !== 3'd1) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b count=%0d want 0 1", i, res_valid, count);
            end
        end
        alloc_valid = 1'b0; cdb_valid = 1'b0;
        rdy = 1'b1;
        cycle();
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_dest !== 32'hA40 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL after_stall: got v=%b t=%b d=%h count=%0d want 1 1 00000a40 0",
                     res_valid, res_taken, res_dest, count);
        end
        rdy = 1'b0;
        cycle();
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_holds_pulse: got v=%b want 1", res_valid);
        end
        rdy = 1'b1;
        cycle();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_after_unstall: got v=%b want 0", res_valid);
        end
        push(OP_BEQ, 32'hB00, 32'h4, 4'd9, 4'd0, 32'h0, 32'h0);
        rdy = 1'b0;
        cdb(4'd9, 32'h0);
        rdy = 1'b1;
        idle(3);
        n_checks++;
        if (res_valid !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL cdb_in_stall: got v=%b count=%0d want 0 1", res_valid, count);
        end
        rdy = 1'b0; flush = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0; rdy = 1'b1;
        n_checks++;
        if (count !== 3'd0 || res_valid !== 1'b0 || res_dest !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_in_stall: got count=%0d v=%b d=%h want 0 0 00000000", count, res_valid, res_dest);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 29) == 0);
            alloc_valid  = $urandom_range(0, 1);
            alloc_op     = sinst_t'($urandom_range(0, 6));
            alloc_pc     = $urandom & 32'hFFFF_FFFC;
            alloc_offset = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : 32'hFFFF_FF00;
            alloc_tagx   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 3));
            alloc_tagy   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 3));
            alloc_datax  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            alloc_datay  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            cdb_valid    = ($urandom_range(0, 9) < 4);
            cdb_tag      = 4'($urandom_range(1, 3));
            cdb_data     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            cycle();
            n_checks++;
            if (res_valid !== exp_valid || res_taken !== exp_taken || res_dest !== exp_dest ||
                count !== 3'(mq.size()) || busy !== (mq.size() != 0) ||
                alloc_ready !== (mq.size() < ENTRIES)) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b t=%b d=%h cnt=%0d busy=%b rdy=%b want %b %b %h %0d %b %b",
                         c, res_valid, res_taken, res_dest, count, busy, alloc_ready,
                         exp_valid, exp_taken, exp_dest, mq.size(), mq.size() != 0, mq.size() < ENTRIES);
            end
        end
        rdy = 1'b1; flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        alloc_valid = 1'b0; alloc_op = OP_BEQ; alloc_pc = '0; alloc_offset = '0;
        alloc_tagx = '0; alloc_tagy = '0; alloc_datax = '0; alloc_datay = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        exp_valid = 1'b0; exp_taken = 1'b0; exp_dest = '0;
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_full_wrap();
        test_in_order();
        test_flush_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
